// File: rtl/tick_sched_if.sv
// Configuration handshake bundle for tick_sched: valid/ready plus the channel,
// period and run fields of one configuration request.
interface tick_sched_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned PER_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [PER_W-1:0] cfg_period;
    logic             cfg_run;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_run,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_run,
        output cfg_ready
    );
endinterface

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: one shared prescaler produces a base tick, and
// each channel divides it by a runtime-programmable period into a one-cycle
// enable pulse. Period changes on a running channel wait for its wrap.
// Optional feature macro TICK_SCHED_FREEZE_EN adds a freeze input that stalls
// the prescaler (and therefore every channel) while asserted.
module tick_sched #(
    parameter int unsigned PRE_N = 12000,
    parameter int unsigned PRE_W = 14,
    parameter int unsigned NCH   = 4,
    parameter int unsigned CH_W  = 2,
    parameter int unsigned PER_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    tick_sched_if.slave    cfg,
`ifdef TICK_SCHED_FREEZE_EN
    input  logic           freeze,
`endif
    output logic           base_tick,
    output logic [NCH-1:0] tick_out,
    output logic [NCH-1:0] run_status,
    output logic           busy
);

    logic [PRE_W-1:0] pre_cnt;
    logic             hold;

    logic [PER_W-1:0] cnt      [NCH];
    logic [PER_W-1:0] per      [NCH];
    logic [PER_W-1:0] pend_per [NCH];
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   run;

    logic [NCH-1:0]   sel;
    logic [NCH-1:0]   adv;
    logic [NCH-1:0]   wrap;
    logic [NCH-1:0]   take;
    logic             ready_c;
    logic             zero;
    logic             kill;

`ifdef TICK_SCHED_FREEZE_EN
    assign hold = freeze;
`else
    assign hold = 1'b0;
`endif

    // Prescaler; freeze stops the count and suppresses new base ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else if (hold) begin
            base_tick <= 1'b0;
        end else if (pre_cnt == PRE_W'(PRE_N - 1)) begin
            pre_cnt   <= '0;
            base_tick <= 1'b1;
        end else begin
            pre_cnt   <= pre_cnt + PRE_W'(1);
            base_tick <= 1'b0;
        end
    end

    // Channel decode, advance/wrap detection and handshake acceptance.
    always_comb begin
        sel  = '0;
        adv  = '0;
        wrap = '0;
        take = '0;
        for (int i = 0; i < NCH; i++) begin
            sel[i]  = (cfg.cfg_ch == CH_W'(i));
            adv[i]  = run[i] & base_tick;
            wrap[i] = adv[i] & (cnt[i] == per[i] - PER_W'(1));
        end
        // Out-of-range channels select nothing, so they are always ready and dropped.
        ready_c = ~|(sel & pend);
        for (int i = 0; i < NCH; i++) begin
            take[i] = cfg.cfg_valid & ready_c & sel[i];
        end
        zero = (cfg.cfg_period == '0);
        kill = ~cfg.cfg_run | zero;
    end

    assign cfg.cfg_ready = ready_c;

    // Per-channel counter, period, pending period and run state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]      <= '0;
                per[i]      <= '0;
                pend_per[i] <= '0;
            end
            pend     <= '0;
            run      <= '0;
            tick_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tick_out[i] <= 1'b0;
                if (take[i] && (!run[i] || kill)) begin
                    // Stopped channel, or a stop/zero request: apply at once, no tick.
                    per[i]  <= cfg.cfg_period;
                    cnt[i]  <= '0;
                    pend[i] <= 1'b0;
                    run[i]  <= cfg.cfg_run & ~zero;
                end else if (take[i] && wrap[i]) begin
                    // New period lands exactly on a wrap: tick and load directly.
                    per[i]      <= cfg.cfg_period;
                    cnt[i]      <= '0;
                    tick_out[i] <= 1'b1;
                end else begin
                    if (take[i]) begin
                        pend_per[i] <= cfg.cfg_period;
                        pend[i]     <= 1'b1;
                    end
                    if (wrap[i]) begin
                        cnt[i]      <= '0;
                        tick_out[i] <= 1'b1;
                        if (pend[i]) begin
                            per[i]  <= pend_per[i];
                            pend[i] <= 1'b0;
                        end
                    end else if (adv[i]) begin
                        cnt[i] <= cnt[i] + PER_W'(1);
                    end
                end
            end
        end
    end

    assign run_status = run;
    assign busy       = |pend;

endmodule
